// File: rtl/quad_decoder_pkg.sv
// Shared types and the quadrature direction table for the quadrature decoder.
package quad_decoder_pkg;

  localparam int unsigned PHASE_W = 2;

  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE    = 2'd0,
    DIR_UP      = 2'd1,
    DIR_DOWN    = 2'd2,
    DIR_ILLEGAL = 2'd3
  } dir_e;

  // 2-bit dir_e code per {prev,next} index; forward Gray order is 00,01,11,10.
  localparam logic [31:0] DIR_LUT = 32'h1B8D_72E4;

  function automatic dir_e dir_lookup(input phase_t prev, input phase_t next);
    logic [4:0] w_base;
    w_base = {prev, next, 1'b0};
    return dir_e'(DIR_LUT[w_base +: 2]);
  endfunction

endpackage

// File: rtl/sync_filter.sv
// Two-flop synchronizer followed by a stability filter; o_valid pulses for
// one cycle each time a value has held for FILTER consecutive clocks.
module sync_filter
  import quad_decoder_pkg::*;
#(
  parameter int unsigned W      = PHASE_W,
  parameter int unsigned FILTER = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic         o_valid
);

  localparam int unsigned CNT_W = 4;

  logic [W-1:0]     r_s1;
  logic [W-1:0]     r_s2;
  logic [1:0]       r_fill;
  logic [W-1:0]     r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_q;
  logic             r_valid;

  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_new;
  logic             w_accept;

  // r_fill keeps the filter idle until the synchronizer carries real samples.
  always_comb begin
    w_cnt_nx = r_cnt;
    w_new    = 1'b0;
    w_accept = 1'b0;
    if (r_s2 != r_cand) begin
      w_cnt_nx = CNT_W'(1);
    end else if (r_cnt != CNT_W'(FILTER)) begin
      w_cnt_nx = r_cnt + CNT_W'(1);
    end
    w_new    = (r_s2 != r_cand) || (r_cnt != CNT_W'(FILTER));
    w_accept = r_fill[1] && w_new && (w_cnt_nx == CNT_W'(FILTER));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_fill  <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_s1    <= i_d;
      r_s2    <= r_s1;
      r_fill  <= {r_fill[0], 1'b1};
      r_valid <= w_accept;
      if (r_fill[1]) begin
        r_cand <= r_s2;
        r_cnt  <= w_cnt_nx;
      end
      if (w_accept) begin
        r_q <= r_s2;
      end
    end
  end

  assign o_q     = r_q;
  assign o_valid = r_valid;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B phase tracking, registered step/direction
// pulses, illegal-transition flag and a wrapping position counter.
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned FILTER = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic             step,
  output logic             up_down,
  output logic [WIDTH-1:0] position,
  output logic             error
);

  phase_t           w_phase;
  logic             w_valid;
  dir_e             w_dir;

  state_e           r_state;
  phase_t           r_prev;
  logic [WIDTH-1:0] r_pos;
  logic             r_ud;
  logic             r_step;
  logic             r_err;

  state_e           w_state_nx;
  phase_t           w_prev_nx;
  logic [WIDTH-1:0] w_pos_nx;
  logic             w_ud_nx;
  logic             w_step_nx;
  logic             w_err_nx;

  sync_filter #(
    .W      (PHASE_W),
    .FILTER (FILTER)
  ) u_sync_filter (
    .clk     (clk),
    .reset   (reset),
    .i_d     ({a, b}),
    .o_q     (w_phase),
    .o_valid (w_valid)
  );

  assign w_dir = dir_lookup(r_prev, w_phase);

  // Next-state and output decode; only an accepted phase can change anything.
  always_comb begin
    w_state_nx = r_state;
    w_prev_nx  = r_prev;
    w_pos_nx   = r_pos;
    w_ud_nx    = r_ud;
    w_step_nx  = 1'b0;
    w_err_nx   = 1'b0;
    if (w_valid) begin
      w_prev_nx = w_phase;
      case (r_state)
        ST_INIT: begin
          w_state_nx = ST_TRACK;
        end
        ST_TRACK: begin
          case (w_dir)
            DIR_UP: begin
              w_step_nx = 1'b1;
              w_ud_nx   = 1'b1;
              w_pos_nx  = r_pos + WIDTH'(1);
            end
            DIR_DOWN: begin
              w_step_nx = 1'b1;
              w_ud_nx   = 1'b0;
              w_pos_nx  = r_pos - WIDTH'(1);
            end
            DIR_ILLEGAL: begin
              w_err_nx = 1'b1;
            end
            default: ;
          endcase
        end
        default: w_state_nx = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_INIT;
      r_prev  <= '0;
      r_pos   <= '0;
      r_ud    <= 1'b0;
      r_step  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_prev  <= w_prev_nx;
      r_pos   <= w_pos_nx;
      r_ud    <= w_ud_nx;
      r_step  <= w_step_nx;
      r_err   <= w_err_nx;
    end
  end

  assign step     = r_step;
  assign up_down  = r_ud;
  assign position = r_pos;
  assign error    = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: a Gray-index reference model queues
// expected step/error events that a negedge monitor pops and compares.
module tb_quad_decoder;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned FILTER = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             a = 1'b0;
  logic             b = 1'b0;
  logic             step;
  logic             up_down;
  logic             error;
  logic [WIDTH-1:0] position;

  quad_decoder #(.WIDTH(WIDTH), .FILTER(FILTER)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .step     (step),
    .up_down  (up_down),
    .position (position),
    .error    (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit               err;
    bit               ud;
    logic [WIDTH-1:0] pos;
    int               cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [1:0]       m_prev;
  logic [WIDTH-1:0] m_pos;
  bit               m_ud;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Position of a phase along the forward sequence 00,01,11,10.
  function automatic int gidx(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] fwd(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model(input logic [1:0] ph, input int m);
    int   d;
    exp_t e;
    d     = (gidx(ph) - gidx(m_prev) + 4) % 4;
    e.cyc = m + 3 + int'(FILTER);
    if (d == 1) begin
      m_pos = m_pos + 1'b1;
      m_ud  = 1'b1;
    end else if (d == 3) begin
      m_pos = m_pos - 1'b1;
      m_ud  = 1'b0;
    end
    e.err = (d == 2);
    e.ud  = m_ud;
    e.pos = m_pos;
    if (d != 0) q.push_back(e);
    m_prev = ph;
  endtask

  // Monitor: every step/error pulse must match the head of the queue.
  exp_t me;
  always @(negedge clk) begin
    if (reset) begin
      if (step && error) check("step_and_error", 32'd1, 32'd0);
      if (step || error) begin
        if (q.size() == 0) begin
          check("unexpected_output", {30'd0, step, error}, 32'd0);
        end else begin
          me = q.pop_front();
          check("event_is_error", {31'd0, error}, {31'd0, me.err});
          check("event_cycle", cyc, me.cyc);
          check("event_up_down", {31'd0, up_down}, {31'd0, me.ud});
          check("event_position", {28'd0, position}, {28'd0, me.pos});
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        me = q.pop_front();
        check("missing_event_cycle", cyc, me.cyc);
      end
    end
  end

  task automatic drive(input logic [1:0] ph, input int gap);
    @(posedge clk);
    #1;
    {a, b} = ph;
    model(ph, cyc);
    repeat (gap) @(posedge clk);
    #1;
    check("hold_position", {28'd0, position}, {28'd0, m_pos});
    check("hold_up_down", {31'd0, up_down}, {31'd0, m_ud});
  endtask

  task automatic check_zero(input string name);
    check({name, "_step"}, {31'd0, step}, 32'd0);
    check({name, "_error"}, {31'd0, error}, 32'd0);
    check({name, "_up_down"}, {31'd0, up_down}, 32'd0);
    check({name, "_position"}, {28'd0, position}, 32'd0);
  endtask

  task automatic reset_pulse(input int ncyc);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_zero("reset_immediate");
    q.delete();
    repeat (ncyc) @(posedge clk);
    #1;
    check_zero("reset_held");
    reset  = 1'b1;
    m_pos  = '0;
    m_ud   = 1'b0;
    m_prev = {a, b};
    repeat (12) @(posedge clk);
    #1;
    check_zero("after_release");
  endtask

  initial begin
    logic [1:0] ph;
    m_prev = 2'b00;
    m_pos  = '0;
    m_ud   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    reset = 1'b1;
    repeat (12) @(posedge clk);

    // Reverse step from zero wraps to all-ones, then forward back to zero.
    drive(2'b10, 10);
    check("wrap_down_position", {28'd0, position}, 32'd15);
    drive(2'b00, 10);
    // Four forward steps.
    drive(2'b01, 10);
    drive(2'b11, 10);
    drive(2'b10, 10);
    drive(2'b00, 10);
    check("four_up_position", {28'd0, position}, 32'd4);
    // Both channels change together, then a legal up step.
    drive(2'b11, 10);
    drive(2'b10, 10);

    // One-cycle glitch on a must be filtered out.
    @(posedge clk);
    #1;
    a = ~a;
    @(posedge clk);
    #1;
    a = ~a;
    repeat (10) @(posedge clk);
    #1;
    check("glitch_position", {28'd0, position}, {28'd0, m_pos});

    for (int i = 0; i < 80; i++) begin
      ph = 2'($urandom_range(0, 3));
      drive(ph, int'($urandom_range(6, 12)));
    end

    // Walk forward to 7, start a change, then reset before it is accepted.
    for (int i = 0; i < 20 && m_pos != WIDTH'(7); i++) drive(fwd(m_prev), 8);
    check("pre_reset_position", {28'd0, position}, 32'd7);
    @(posedge clk);
    #1;
    {a, b} = fwd(m_prev);
    @(posedge clk);
    reset_pulse(3);
    drive(fwd(m_prev), 10);
    drive(fwd(m_prev), 10);
    check("post_reset_position", {28'd0, position}, 32'd2);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    check("queue_drained", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
